// File: rtl/jamma_joy_mux.sv
// Adapter-side responder for the time-multiplexed JAMMA joystick bus.
// It debounces both players, steers the selected one onto JJOY, and releases the bus when select goes quiet.
module jamma_joy_mux #(
   parameter int DB_DIV   = 1024,
   parameter int DB_COUNT = 4,
   parameter int SYNC_SEL = 0,
   parameter int TIMEOUT  = 65536
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       JSELECT,
   input  logic [7:0] P1_IN,
   input  logic [7:0] P2_IN,
   output logic [7:0] JJOY,
   output logic       STALE,
   output logic [7:0] P1_DB,
   output logic [7:0] P2_DB
);
   localparam int PW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DB_DIV - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [2:0]    CNT_LAST = 3'(DB_COUNT);

   logic [15:0]   r_in_s1;
   logic [15:0]   r_in_s2;
   logic [PW-1:0] r_pre;
   logic          r_sel_s1;
   logic          r_sel_s2;
   logic          r_sel_prev;
   logic [WW-1:0] r_wd;
   logic          r_stale;
   logic          w_tick;
   logic          w_sel_edge;
   logic          w_sel_eff;
   logic [15:0]   w_stable;

   // Player 2 occupies the upper byte so one loop covers all 16 switches.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_in_s1 <= 16'hFFFF;
         r_in_s2 <= 16'hFFFF;
      end else begin
         r_in_s1 <= {P2_IN, P1_IN};
         r_in_s2 <= r_in_s1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_pre <= '0;
      end else if (r_pre == PRE_LAST) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   assign w_tick = (r_pre == PRE_LAST);

   for (genvar gi = 0; gi < 16; gi++) begin : g_db
      logic [2:0] r_cnt;
      logic       r_bit;

      always_ff @(posedge CLK) begin
         if (!RST_N) begin
            r_cnt <= '0;
            r_bit <= 1'b1;
         end else if (w_tick) begin
            if (r_in_s2[gi] == r_bit) begin
               r_cnt <= '0;
            end else if (r_cnt + 3'd1 == CNT_LAST) begin
               r_bit <= r_in_s2[gi];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 3'd1;
            end
         end
      end

      assign w_stable[gi] = r_bit;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_sel_s1   <= 1'b0;
         r_sel_s2   <= 1'b0;
         r_sel_prev <= 1'b0;
      end else begin
         r_sel_s1   <= JSELECT;
         r_sel_s2   <= r_sel_s1;
         r_sel_prev <= r_sel_s2;
      end
   end

   // Activity is always judged on the synchronized select, even when the mux uses the raw pin.
   assign w_sel_edge = r_sel_s2 ^ r_sel_prev;
   assign w_sel_eff  = (SYNC_SEL != 0) ? r_sel_s2 : JSELECT;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_wd    <= '0;
         r_stale <= 1'b1;
      end else if (w_sel_edge) begin
         r_wd    <= '0;
         r_stale <= 1'b0;
      end else if (r_wd != WD_LAST) begin
         r_wd <= r_wd + WW'(1);
         if (r_wd + WW'(1) == WD_LAST) begin
            r_stale <= 1'b1;
         end
      end
   end

   always_comb begin
      JJOY = 8'hFF;
      if (!r_stale) begin
         JJOY = w_sel_eff ? w_stable[15:8] : w_stable[7:0];
      end
   end

   assign STALE = r_stale;
   assign P1_DB = w_stable[7:0];
   assign P2_DB = w_stable[15:8];

endmodule

// File: tb/tb_jamma_joy_mux.sv
// Directed bench for jamma_joy_mux: direct-select and synchronized-select instances share one stimulus,
// checked every cycle against a cycle-count model plus hand-computed points.
module tb_jamma_joy_mux;
   localparam int DBD = 4;
   localparam int DBC = 4;
   localparam int TO  = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       jsel;
   logic [7:0] p1_in;
   logic [7:0] p2_in;
   logic [7:0] jjoy0, p1db0, p2db0;
   logic [7:0] jjoy1, p1db1, p2db1;
   logic       stale0, stale1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jamma_joy_mux #(.DB_DIV(DBD), .DB_COUNT(DBC), .SYNC_SEL(0), .TIMEOUT(TO)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .JSELECT(jsel), .P1_IN(p1_in), .P2_IN(p2_in),
      .JJOY(jjoy0), .STALE(stale0), .P1_DB(p1db0), .P2_DB(p2db0)
   );

   jamma_joy_mux #(.DB_DIV(DBD), .DB_COUNT(DBC), .SYNC_SEL(1), .TIMEOUT(TO)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .JSELECT(jsel), .P1_IN(p1_in), .P2_IN(p2_in),
      .JJOY(jjoy1), .STALE(stale1), .P1_DB(p1db1), .P2_DB(p2db1)
   );

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: inputs are seen two edges late, a tick is every DBD-th edge since reset,
   // a bit flips after DBC ticks in a row that disagree, and stale means no detected edge for TO-1 edges.
   logic [7:0]  m_p1_q [2];
   logic [7:0]  m_p2_q [2];
   logic [15:0] m_stable;
   int          m_run [16];
   int          m_cyc;
   logic [2:0]  m_selq;
   int          m_since;
   bit          m_seen;
   bit          m_valid = 1'b0;

   task automatic model_step();
      logic [15:0] synced;
      logic        sel_edge;
      if (!rst_n) begin
         m_p1_q[0] = 8'hFF; m_p1_q[1] = 8'hFF;
         m_p2_q[0] = 8'hFF; m_p2_q[1] = 8'hFF;
         m_stable  = 16'hFFFF;
         for (int b = 0; b < 16; b++) m_run[b] = 0;
         m_cyc   = 0;
         m_selq  = 3'b000;
         m_since = 0;
         m_seen  = 1'b0;
      end else begin
         synced = {m_p2_q[1], m_p1_q[1]};
         if (m_cyc % DBD == DBD - 1) begin
            for (int b = 0; b < 16; b++) begin
               if (synced[b] != m_stable[b]) begin
                  m_run[b]++;
                  if (m_run[b] == DBC) begin
                     m_stable[b] = synced[b];
                     m_run[b] = 0;
                  end
               end else begin
                  m_run[b] = 0;
               end
            end
         end
         m_cyc++;
         sel_edge = m_selq[1] != m_selq[2];
         if (sel_edge) begin
            m_since = 0;
            m_seen  = 1'b1;
         end else begin
            m_since++;
         end
         m_selq    = {m_selq[1], m_selq[0], jsel};
         m_p1_q[1] = m_p1_q[0]; m_p1_q[0] = p1_in;
         m_p2_q[1] = m_p2_q[0]; m_p2_q[0] = p2_in;
      end
      m_valid = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      logic       e_stale;
      logic [7:0] e_j0, e_j1;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            e_stale = !m_seen || (m_since >= TO - 1);
            e_j0 = e_stale ? 8'hFF : (jsel ? m_stable[15:8] : m_stable[7:0]);
            e_j1 = e_stale ? 8'hFF : (m_selq[1] ? m_stable[15:8] : m_stable[7:0]);
            chk1("mdl_stale0", stale0, e_stale);
            chk1("mdl_stale1", stale1, e_stale);
            chk8("mdl_jjoy0", jjoy0, e_j0);
            chk8("mdl_jjoy1", jjoy1, e_j1);
            chk8("mdl_p1db0", p1db0, m_stable[7:0]);
            chk8("mdl_p2db0", p2db0, m_stable[15:8]);
            chk8("mdl_p1db1", p1db1, m_stable[7:0]);
            chk8("mdl_p2db1", p2db1, m_stable[15:8]);
         end
      end
   end

   initial begin
      int   fall;
      logic h1, h2;
      rst_n = 1'b0; jsel = 1'b0; p1_in = 8'hFF; p2_in = 8'hFF;

      // Reset held while inputs are active
      @(posedge clk); #1 p1_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 jsel = ~jsel;
         #2;
         chk8("rst_jjoy0", jjoy0, 8'hFF);
         chk8("rst_jjoy1", jjoy1, 8'hFF);
         chk1("rst_stale", stale0, 1'b1);
         chk8("rst_p1db", p1db0, 8'hFF);
      end
      @(posedge clk); #1 rst_n = 1'b1; p1_in = 8'hFF; jsel = 1'b0;
      repeat (5) @(posedge clk);

      // Clean fall on P1_IN[0]
      @(posedge clk); #1 p1_in = 8'hFE;
      fall = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (fall < 0 && p1db0[0] == 1'b0) fall = k;
      end
      chk1("p1_fall_window", (fall >= 14 && fall <= 18), 1'b1);
      chk8("p1_db_after", p1db0, 8'hFE);

      // Two-tick glitch on P2_IN[3]
      @(posedge clk); #1 p2_in = 8'hF7;
      repeat (8) @(posedge clk);
      #1 p2_in = 8'hFF;
      repeat (30) @(posedge clk);
      #1 chk8("p2_glitch", p2db0, 8'hFF);

      p2_in = 8'h7F;
      repeat (30) @(posedge clk);
      #1 chk8("p2_start0", p2db0, 8'h7F);
      chk8("p2_start1", p2db1, 8'h7F);
      chk1("idle_stale", stale0, 1'b1);

      // Per-cycle toggling
      h1 = jsel; h2 = jsel;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         h2 = h1; h1 = jsel; jsel = ~jsel;
         #2;
         if (i >= 4) begin
            chk1("tog_stale", stale0, 1'b0);
            chk8("tog_jjoy0", jjoy0, jsel ? 8'h7F : 8'hFE);
            chk8("tog_jjoy1", jjoy1, h2 ? 8'h7F : 8'hFE);
         end
      end

      // Timeout after the last toggle: detected at +3, stale at +18
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 17) chk1("to_before", stale0, 1'b0);
         if (k == 18) begin
            chk1("to_stale", stale0, 1'b1);
            chk8("to_jjoy0", jjoy0, 8'hFF);
            chk8("to_jjoy1", jjoy1, 8'hFF);
         end
      end

      // Recovery: stale clears 3 edges after a toggle
      @(posedge clk); #1 jsel = ~jsel;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (k == 2) chk1("rec_still", stale0, 1'b1);
         if (k == 3) chk1("rec_clear", stale0, 1'b0);
      end

      // Toggle detected on the saturation edge
      repeat (12) @(posedge clk);
      #1 jsel = ~jsel;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         chk1("sat_edge_wins", stale0, 1'b0);
      end

      // Mid-operation reset
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk8("mid_rst_p1db", p1db0, 8'hFF);
      chk8("mid_rst_p2db", p2db0, 8'hFF);
      chk1("mid_rst_stale", stale0, 1'b1);
      chk8("mid_rst_jjoy", jjoy0, 8'hFF);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jamma_joy_mux.md
# jamma_joy_mux

Responder end of the time-multiplexed JAMMA joystick bus. The host core toggles `JSELECT` and samples the shared 8-bit `JJOY` bus into player 1 (JSELECT=0) or player 2 (JSELECT=1). This block sits on the adapter side and performs four functions:
- debounces both players' raw active-low switch inputs;
- drives the player selected by `JSELECT` onto `JJOY`;
- watches select activity;
- releases the bus (all ones) when the host stops toggling.

## Interface
Parameters:
- `DB_DIV`, 1024: CLK cycles per debounce sample tick (≥2).
- `DB_COUNT`, 4: consecutive disagreeing ticks needed to flip a stable bit (1..7).
- `SYNC_SEL`, 0: 0 = `JSELECT` steers the output mux directly; 1 = `JSELECT` passes through a 2-flop synchronizer first.
- `TIMEOUT`, 65536: CLK cycles without a `JSELECT` edge before the bus is declared stale (≥4).

Ports:
- `CLK`  in  1  single system clock.
- `RST_N`  in  1  reset, synchronous, active-low.
- `JSELECT`  in  1  player select from host: 0 = player 1, 1 = player 2.
- `P1_IN`  in  8  raw player-1 switches, active-low. Bit order matches `JJOY`; [7] = start.
- `P2_IN`  in  8  raw player-2 switches, active-low.
- `JJOY`  out  8  multiplexed debounced bus, active-low.
- `STALE`  out  1  high while no `JSELECT` activity within `TIMEOUT`.
- `P1_DB`  out  8  debounced player-1 state (diagnostic).
- `P2_DB`  out  8  debounced player-2 state (diagnostic).

## Operation
- All state updates on posedge `CLK`. When `RST_N`=0 at an edge, the block resets regardless of other inputs.
- Reset values:
  - `P1_DB` = `P2_DB` = 8'hFF.
  - All debounce counters = 0.
  - Prescaler = 0.
  - `STALE` = 1.
  - Watchdog counter = 0.
  - Select history flops = 0.
  - `JJOY` = 8'hFF.
- Input conditioning: each `P1_IN`/`P2_IN` bit passes through a 2-flop synchronizer (reset to 1).
- Prescaler: counts 0..`DB_DIV`-1 and wraps. `tick` is asserted for one cycle when the count equals `DB_DIV`-1.
- Per-bit debounce (16 independent instances), evaluated only on `tick`:
  - If the synced bit equals the stable bit, the counter clears to 0.
  - Otherwise the counter increments. When the incremented value reaches `DB_COUNT`, the stable bit takes the synced value and the counter clears.
  - Counter width is 3 bits; it never exceeds `DB_COUNT`.
- Select path:
  - `sel_eff` = `JSELECT` when `SYNC_SEL`=0.
  - `sel_eff` = the 2-flop synchronized `JSELECT` when `SYNC_SEL`=1.
- Output mux:
  - `JJOY` = 8'hFF when `STALE`=1.
  - Otherwise `JJOY` = `P2_DB` if `sel_eff`=1, else `P1_DB`.
  - The mux is combinational from registered data and `sel_eff`.
- Watchdog:
  - Edge detect compares the synchronized `JSELECT` against its previous value (always through the synchronizer, independent of `SYNC_SEL`).
  - On an edge: counter clears to 0 and `STALE` clears to 0 at the same edge.
  - With no edge: the counter increments, saturating at `TIMEOUT`-1. Reaching `TIMEOUT`-1 sets `STALE`=1.
  - If an edge and saturation occur at the same edge, the edge wins: `STALE`=0.
- Player inputs never cross: bits of `P1_IN` never appear on `JJOY` while `sel_eff`=1 and `STALE`=0.

## Timing
- `SYNC_SEL`=0: `JJOY` follows `JSELECT` combinationally, settling within the same cycle. This suits a host that toggles select every CLK and samples on the next edge.
- `SYNC_SEL`=1: `JJOY` follows a `JSELECT` change 2 CLK edges later.
- Raw input to debounced output, for a clean level change:
  - 2 cycles of sync,
  - then `DB_COUNT` ticks,
  - so 2 + (`DB_COUNT`-1)·`DB_DIV` to 2 + `DB_COUNT`·`DB_DIV` cycles, depending on prescaler phase.
- Glitches shorter than `DB_COUNT` consecutive ticks are rejected.
- `STALE` deasserts 3 edges after the first `JSELECT` transition: 2 sync edges plus the edge-detect edge.
- `STALE` asserts `TIMEOUT`-1 cycles after the last detected edge.
- Reset mid-operation: all state returns to reset values at the first edge with `RST_N`=0. Pending debounce counts are discarded.

## Test plan
- Reset, then hold `RST_N`=0 for 3 cycles while `P1_IN`=8'h00 and `JSELECT` toggles: `JJOY`=8'hFF, `STALE`=1, `P1_DB`=8'hFF throughout.
- `DB_DIV`=4, `DB_COUNT`=4, `P1_IN`[0] driven 0 steadily: `P1_DB`[0] falls between cycle 14 and cycle 18 after the change; other bits stay 1.
- `P2_IN`[3] pulse low for 2 ticks, then high (same parameters): `P2_DB` stays 8'hFF.
- `SYNC_SEL`=0, `P1_DB`=8'hFE, `P2_DB`=8'h7F, `JSELECT` toggling every cycle after 3 warm-up edges: `STALE`=0 and `JJOY` alternates FE/7F in phase with `JSELECT` each cycle. Repeat with `SYNC_SEL`=1: same alternation delayed 2 cycles.
- `TIMEOUT`=16, `JSELECT` held constant after activity: `STALE` rises at cycle 15 after the last edge and `JJOY`=8'hFF. The next toggle clears `STALE` 3 cycles later.
- `TIMEOUT`=16, toggle arriving exactly on the saturation cycle: `STALE` stays 0.
